// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 8x8 multiplier accumulation stage.
// Holds the product width, default run length / accumulator width and the
// accumulator FSM state type.
package binary_mul_pkg;

  localparam int unsigned P_W       = 16;
  localparam int unsigned LEN_DEF   = 16;
  localparam int unsigned ACC_W_DEF = 24;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/binary_mul_acc_uni_if.sv
// Product-in / result-out handshake bundle for binary_mul_acc_uni.
//   p_valid, P   : product stream from the multiplier
//   p_ready      : stage accepts products (drives the multiplier enable)
//   acc_out      : result, acc_valid / acc_ready handshake
//   ovf          : sticky saturation flag for the presented result
// slave  = accumulator side, master = producer/consumer side.
interface binary_mul_acc_uni_if import binary_mul_pkg::*; #(
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic             p_valid;
  logic [P_W-1:0]   P;
  logic             p_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;

  modport slave (
    input  p_valid, P, acc_ready,
    output p_ready, acc_out, acc_valid, ovf
  );

  modport master (
    output p_valid, P, acc_ready,
    input  p_ready, acc_out, acc_valid, ovf
  );

endinterface

// File: rtl/binary_mul_acc_add.sv
// Accumulator adder: acc + zero-extended product, formed ACC_W+1 bits wide.
// Build option BINARY_MUL_ACC_SAT_EN: when defined, a carry out clamps the
// sum to all-ones and raises clamp; otherwise the sum wraps and clamp is 0.
// Ports: acc (running sum), p (product), sum (next sum), clamp (saturated).
module binary_mul_acc_add import binary_mul_pkg::*; #(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             clamp
);

  logic [ACC_W:0] wide;

  assign wide = {1'b0, acc} + (ACC_W+1)'(p);

`ifdef BINARY_MUL_ACC_SAT_EN
  // Once clamped, every further addition carries out again, so it stays all-ones.
  assign clamp = wide[ACC_W];
  assign sum   = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  logic carry_unused;

  // Modulo-2^ACC_W accumulation: the carry is dropped.
  assign carry_unused = wide[ACC_W];
  assign clamp        = 1'b0;
  assign sum          = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/binary_mul_acc_uni.sv
// Accumulation stage behind the 8x8 unsigned multiplier: sums LEN accepted
// products into one result presented on a valid/ready handshake.
// Ports: clk, rst_n (async active-low), en (global freeze when low),
//        bus (slave modport: p_valid/P/p_ready in, acc_out/acc_valid/
//        acc_ready/ovf out).
// Parameters: LEN (2..256 products per result), ACC_W (>= 16).
// Build option BINARY_MUL_ACC_SAT_EN selects saturating accumulation
// (applied inside binary_mul_acc_add).
module binary_mul_acc_uni import binary_mul_pkg::*; #(
  parameter int unsigned LEN   = LEN_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 en,
  binary_mul_acc_uni_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_valid_q, acc_valid_d;
  logic             ovf_q, ovf_d;
  logic             ovf_run_q, ovf_run_d;

  logic [ACC_W-1:0] sum;
  logic             clamp;
  logic             accept;
  logic             last;

  binary_mul_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc_q),
    .p     (bus.P),
    .sum   (sum),
    .clamp (clamp)
  );

  assign accept = en && bus.p_valid && (state_q == ACCUM);
  assign last   = (cnt_q == CNT_W'(LEN - 1));

  // Next-state and register-input logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    ovf_d       = ovf_q;
    ovf_run_d   = ovf_run_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last) begin
            acc_out_d   = sum;
            acc_valid_d = 1'b1;
            ovf_d       = ovf_run_q | clamp;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_run_d   = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d     = sum;
            cnt_d     = cnt_q + CNT_W'(1);
            ovf_run_d = ovf_run_q | clamp;
          end
        end
      end
      HOLD: begin
        // Products are ignored here; only the result handshake moves state.
        if (en && bus.acc_ready) begin
          acc_valid_d = 1'b0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
      ovf_run_q   <= ovf_run_d;
    end
  end

  // p_ready decodes state only, so it follows reset asynchronously.
  assign bus.p_ready   = (state_q == ACCUM);
  assign bus.acc_out   = acc_out_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_binary_mul_acc_uni.sv
// Self-checking bench for binary_mul_acc_uni: a 24-bit and a 16-bit
// accumulator instance share one stimulus stream; table-driven runs plus
// hand-written reset, backpressure, stall and reset-mid-run sequences.
module tb_binary_mul_acc_uni;
  import binary_mul_pkg::*;

`ifdef BINARY_MUL_ACC_SAT_EN
  localparam logic [15:0] FS16     = 16'd65535;
  localparam logic        FS16_OVF = 1'b1;
`else
  localparam logic [15:0] FS16     = 16'd57360;
  localparam logic        FS16_OVF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  binary_mul_acc_uni_if #(.ACC_W(24)) bus24 ();
  binary_mul_acc_uni_if #(.ACC_W(16)) bus16 ();

  assign bus16.p_valid   = bus24.p_valid;
  assign bus16.P         = bus24.P;
  assign bus16.acc_ready = bus24.acc_ready;

  binary_mul_acc_uni #(.LEN(16), .ACC_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus24)
  );

  binary_mul_acc_uni #(.LEN(16), .ACC_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus16)
  );

  typedef struct {
    logic [15:0] start;
    logic [15:0] step;
    int          gap;
    logic [23:0] exp24;
    logic [15:0] exp16;
    logic        ovf16;
  } vec_t;

  vec_t tbl [6];
  int   checks    = 0;
  int   failures  = 0;
  int   busy_bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One accepted product; we sit on a negedge before and after.
  task automatic put(input logic [15:0] p);
    if (bus24.p_ready !== 1'b1 || bus24.acc_valid !== 1'b0) busy_bad++;
    bus24.p_valid = 1'b1;
    bus24.P       = p;
    @(negedge clk);
    bus24.p_valid = 1'b0;
    bus24.P       = 16'hFFFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_result(input string name, input logic [23:0] e24,
                              input logic [15:0] e16, input logic o16);
    chk({name, "_busy"},    32'(busy_bad), 32'd0);
    busy_bad = 0;
    chk({name, "_valid"},   32'(bus24.acc_valid), 32'd1);
    chk({name, "_out"},     32'(bus24.acc_out), 32'(e24));
    chk({name, "_ovf"},     32'(bus24.ovf), 32'd0);
    chk({name, "_pready"},  32'(bus24.p_ready), 32'd0);
    chk({name, "_valid16"}, 32'(bus16.acc_valid), 32'd1);
    chk({name, "_out16"},   32'(bus16.acc_out), 32'(e16));
    chk({name, "_ovf16"},   32'(bus16.ovf), 32'(o16));
  endtask

  task automatic take(input string name);
    bus24.acc_ready = 1'b1;
    @(negedge clk);
    bus24.acc_ready = 1'b0;
    chk({name, "_take_valid"}, 32'(bus24.acc_valid), 32'd0);
    chk({name, "_take_pready"}, 32'(bus24.p_ready), 32'd1);
    chk({name, "_take_ovf16"}, 32'(bus16.ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd1,     16'd1,   0, 24'd136,     16'd136,   1'b0};
    tbl[1] = '{16'd0,     16'd0,   0, 24'd0,       16'd0,     1'b0};
    tbl[2] = '{16'd65025, 16'd0,   0, 24'd1040400, FS16,      FS16_OVF};
    tbl[3] = '{16'd10,    16'd5,   1, 24'd760,     16'd760,   1'b0};
    tbl[4] = '{16'd1000,  16'd100, 0, 24'd28000,   16'd28000, 1'b0};
    tbl[5] = '{16'd2,     16'd0,   2, 24'd32,      16'd32,    1'b0};

    bus24.p_valid   = 1'b0;
    bus24.P         = 16'd0;
    bus24.acc_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_valid",  32'(bus24.acc_valid), 32'd0);
    chk("rst_pready", 32'(bus24.p_ready), 32'd1);
    chk("rst_out",    32'(bus24.acc_out), 32'd0);
    chk("rst_ovf",    32'(bus24.ovf), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    en       = 1'b1;
    bus24.P  = 16'd100;
    idle(3);
    chk("idle_out",    32'(bus24.acc_out), 32'd0);
    chk("idle_valid",  32'(bus24.acc_valid), 32'd0);
    chk("idle_pready", 32'(bus24.p_ready), 32'd1);

    // Table-driven runs; the first also shows the idle P=100 was not summed.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) idle(tbl[v].gap);
        put(tbl[v].start + 16'(i) * tbl[v].step);
      end
      check_result($sformatf("run%0d", v), tbl[v].exp24, tbl[v].exp16, tbl[v].ovf16);
      idle(1);
      chk($sformatf("run%0d_hold", v), 32'(bus24.acc_out), 32'(tbl[v].exp24));
      take($sformatf("run%0d", v));
    end

    // Backpressure: result held 5 cycles while products are offered.
    for (int i = 0; i < 16; i++) put(16'(i + 1));
    check_result("bp", 24'd136, 16'd136, 1'b0);
    begin
      int bad = 0;
      bus24.p_valid = 1'b1;
      bus24.P       = 16'd777;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus24.acc_valid !== 1'b1 || bus24.acc_out !== 24'd136 ||
            bus24.p_ready !== 1'b0) bad++;
      end
      chk("bp_stable", 32'(bad), 32'd0);
    end
    // en low freezes the pending handshake even with acc_ready high.
    en = 1'b0;
    bus24.acc_ready = 1'b1;
    idle(3);
    chk("bp_en_freeze", 32'(bus24.acc_valid), 32'd1);
    bus24.p_valid = 1'b0;
    bus24.acc_ready = 1'b0;
    en = 1'b1;
    take("bp");
    for (int i = 0; i < 16; i++) put(16'd2);
    check_result("bp_next", 24'd32, 16'd32, 1'b0);
    take("bp_next");

    // en low mid-run for 3 cycles with a product offered.
    for (int i = 0; i < 8; i++) put(16'(i + 1));
    en = 1'b0;
    bus24.p_valid = 1'b1;
    bus24.P       = 16'd5000;
    idle(3);
    bus24.p_valid = 1'b0;
    en = 1'b1;
    for (int i = 8; i < 16; i++) put(16'(i + 1));
    check_result("stall", 24'd136, 16'd136, 1'b0);

    // Asynchronous reset while a result is pending.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(bus24.acc_valid), 32'd0);
    chk("arst_pready", 32'(bus24.p_ready), 32'd1);
    chk("arst_out",    32'(bus24.acc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after 7 accepted products discards the partial sum.
    for (int i = 0; i < 7; i++) put(16'd1000);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) put(16'd2);
    check_result("midrst", 24'd32, 16'd32, 1'b0);
    take("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_mul_acc_uni.md
# binary_mul_acc_uni

Downstream accumulation stage for the 8×8 unsigned multiplier. It sits directly on the multiplier's registered 16-bit product `P` and sums a fixed-length run of `LEN` products into one dot-product result. The result is presented on a valid/ready output handshake. Its `p_ready` output drives the multiplier's `en`, so the multiplier stalls while a finished result waits to be taken.

## Interface

Parameters:
- `LEN`, default 16: number of products per result; legal range 2..256.
- `ACC_W`, default 24: accumulator and result width; must be ≥ 16.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  global enable; when low, no state changes and all outputs hold.
- `p_valid`  in  1  `P` carries a product to accumulate this cycle.
- `P`  in  16  unsigned product from the multiplier.
- `p_ready`  out  1  stage accepts products; wired to the multiplier's `en`.
- `acc_out`  out  `ACC_W`  registered result.
- `acc_valid`  out  1  `acc_out` holds a complete result.
- `acc_ready`  in  1  consumer takes the result.
- `ovf`  out  1  sticky saturation flag for the current result.

## Operation

- Two states: `ACCUM` and `HOLD`. Reset enters `ACCUM`.
- Reset values: `acc` = 0, `cnt` = 0, `acc_out` = 0, `acc_valid` = 0, `ovf` = 0.
- `p_ready` = (state == `ACCUM`). It is combinational from state only and never depends on `p_valid`.
- A product is **accepted** when `en && p_valid && p_ready`.
- In `ACCUM`, on an accepted product with `cnt < LEN-1`:
  - `acc <= acc + P` (`P` zero-extended to `ACC_W`);
  - `cnt <= cnt + 1`.
- In `ACCUM`, on an accepted product with `cnt == LEN-1`:
  - `acc_out <= acc + P`;
  - `acc_valid <= 1`;
  - `acc <= 0`, `cnt <= 0`;
  - go to `HOLD`.
- In `ACCUM` with no accepted product: hold all state.
- In `HOLD`:
  - `acc_out` and `ovf` are stable;
  - `p_valid` is ignored;
  - when `en && acc_ready`: `acc_valid <= 0`, `ovf <= 0`, go to `ACCUM`.
- Arithmetic: unsigned; the sum is computed ACC_W+1 bits wide; overflow handling is set by Configuration.
- `cnt` width is `$clog2(LEN)`. It never wraps past `LEN-1`.
- `en` low in either state freezes everything, including a pending handshake. `acc_ready` is not sampled while `en` is low.
- Reset mid-run discards the partial sum and any pending result. `acc_valid` and `p_ready` respond asynchronously: on `rst_n` falling, `acc_valid` = 0 and `p_ready` = 1 immediately.

## Timing

- Result latency: `acc_valid` rises in the cycle after the edge that accepts the `LEN`-th product.
- `acc_out` equals the sum of exactly those `LEN` accepted products.
- Minimum of one `HOLD` cycle per result.
- Maximum throughput: one result per `LEN`+1 cycles, with `acc_ready` tied high.
- End-to-end latency with the multiplier: one multiplier cycle, plus `LEN` accept cycles, plus one cycle.
- No combinational path from `acc_ready` or `p_valid` to any output.

## Configuration

- Macro: `BINARY_MUL_ACC_SAT_EN`.
- Defined:
  - any sum exceeding 2^ACC_W−1 clamps `acc` to all-ones;
  - further additions keep it at all-ones;
  - `ovf` goes high with `acc_valid` if clamping occurred in that run.
- Undefined:
  - sums wrap modulo 2^ACC_W;
  - `ovf` is tied to 0.
- With the defaults there is no overflow in either mode: 16 × 65025 = 1 040 400 < 2^24.

## Structure

- Shared package `binary_mul_pkg` holds:
  - the state enum (`ACCUM`, `HOLD`);
  - the product width constant `P_W` = 16;
  - the default `LEN` and `ACC_W` constants.
- One sub-module, `binary_mul_acc_add`: the ACC_W+1-bit adder plus saturation clamp. The macro is applied only inside it.
- The FSM, counter and output registers stay in the top module.

## Test plan

- **Reset:** hold `rst_n` low, then release → all outputs 0 except `p_ready` = 1; drive `P` = 100 with `p_valid` = 0 → no change.
- **Basic run** (`LEN` = 16): products 1..16 back-to-back → `acc_valid` one cycle after the 16th, `acc_out` = 136, `p_ready` = 0 during `HOLD`.
- **Backpressure and stall:**
  - `acc_ready` low for 5 cycles → `acc_out`/`acc_valid` stable, `p_ready` = 0;
  - `en` low mid-run for 3 cycles → sum unaffected;
  - gapped `p_valid` → only accepted products count.
- **Full-scale** (`LEN` = 16, `ACC_W` = 24): 16 × 65025 → `acc_out` = 1 040 400, `ovf` = 0; next run starts from 0.
- **Overflow** (`ACC_W` = 16): 16 × 65025 → with `BINARY_MUL_ACC_SAT_EN`, `acc_out` = 65535 and `ovf` = 1; without it, `acc_out` = 1 040 400 mod 65536 = 57 360 and `ovf` = 0.
- **Reset mid-run:** 7 products accepted, then assert `rst_n` → a fresh run of 16 × 2 gives `acc_out` = 32.
